// File: rtl/r200_pkg.sv
// Shared definitions for the R200 fetch front end.
// Holds the NOP encoding, the PC step and the fetch FSM state type.
package r200_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

endpackage

// File: rtl/r200_ifid_reg.sv
// IF/ID pipeline register: hold by default, load a fetched word,
// or flush to a NOP bubble (flush wins over load).
module r200_ifid_reg
  import r200_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pcp4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcp4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pcp4;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP;
      r_pc    <= RESET_PC;
      r_pcp4  <= RESET_PC + PC_INC;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pcp4  <= i_pcp4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pcp4  = r_pcp4;
  assign o_valid = r_valid;

endmodule

// File: rtl/r200_if.sv
// R200 instruction fetch stage: single-outstanding fetch FSM,
// one-entry skid buffer for decode stalls, redirect flushing.
module r200_if
  import r200_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrn,
  output logic [31:0] pc_addrout,
  output logic [31:0] pcp4,
  output logic        id_valid
);

  state_t      r_state;
  state_t      w_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_inc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_pcp4;
  logic        w_load;
  logic        w_flush;
  logic        w_use_skid;
  logic        w_skid_we;
  logic [31:0] w_ld_instr;
  logic [31:0] w_ld_pc;
  logic [31:0] w_ld_pcp4;

  assign w_pc_inc = r_pc + PC_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_skid_instr <= NOP;
      r_skid_pc    <= RESET_PC;
      r_skid_pcp4  <= RESET_PC + PC_INC;
    end else begin
      r_state <= w_nxt;
      r_pc    <= w_pc_nxt;
      if (w_skid_we) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_pc;
        r_skid_pcp4  <= w_pc_inc;
      end
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_pc_nxt   = r_pc;
    w_load     = 1'b0;
    w_flush    = 1'b0;
    w_use_skid = 1'b0;
    w_skid_we  = 1'b0;
    unique case (r_state)
      S_IDLE: w_nxt = S_REQ;
      S_REQ: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          w_nxt    = S_DROP;
        end else begin
          w_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          w_nxt    = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid && !stall) begin
          w_load   = 1'b1;
          w_pc_nxt = w_pc_inc;
          w_nxt    = S_REQ;
        end else if (imem_valid) begin
          w_skid_we = 1'b1;
          w_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          w_nxt    = S_REQ;
        end else if (!stall) begin
          w_load     = 1'b1;
          w_use_skid = 1'b1;
          w_pc_nxt   = w_pc_inc;
          w_nxt      = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) w_pc_nxt = redirect_pc;
        if (imem_valid) w_nxt = S_REQ;
      end
      default: w_nxt = S_IDLE;
    endcase
    // A consumed word with nothing new behind it becomes a bubble
    if (r_state != S_IDLE && (redirect || (!stall && !w_load)))
      w_flush = 1'b1;
  end

  assign w_ld_instr = w_use_skid ? r_skid_instr : imem_rdata;
  assign w_ld_pc    = w_use_skid ? r_skid_pc    : r_pc;
  assign w_ld_pcp4  = w_use_skid ? r_skid_pcp4  : w_pc_inc;

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;

  r200_ifid_reg #(.RESET_PC(RESET_PC)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (w_ld_instr),
    .i_pc    (w_ld_pc),
    .i_pcp4  (w_ld_pcp4),
    .o_instr (instrn),
    .o_pc    (pc_addrout),
    .o_pcp4  (pcp4),
    .o_valid (id_valid)
  );

endmodule

// File: tb/tb_r200_if.sv
// Directed testbench for r200_if: reset, fetch, skid,
// redirects, PC wrap and reset during a held fetch.
module tb_r200_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrn;
  logic [31:0] pc_addrout;
  logic [31:0] pcp4;
  logic        id_valid;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  r200_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instrn      (instrn),
    .pc_addrout  (pc_addrout),
    .pcp4        (pcp4),
    .id_valid    (id_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_valid = 1'b0; imem_rdata = '0;
    cyc(); cyc();
    n_chk++; if (instrn !== 32'h13) begin n_bad++; $display("FAIL rst_instrn got=%h exp=%h", instrn, 32'h13); end
    n_chk++; if (pc_addrout !== 32'h0) begin n_bad++; $display("FAIL rst_pc got=%h exp=0", pc_addrout); end
    n_chk++; if (pcp4 !== 32'h4) begin n_bad++; $display("FAIL rst_pcp4 got=%h exp=4", pcp4); end
    n_chk++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    rst = 1'b0;
    #2;
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    cyc();
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_first_fetch();
    cyc();
    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    cyc();
    imem_valid = 1'b0;
    n_chk++; if (instrn !== 32'h0050_0093) begin n_bad++; $display("FAIL ff_instr got=%h exp=00500093", instrn); end
    n_chk++; if (pc_addrout !== 32'h0) begin n_bad++; $display("FAIL ff_pc got=%h exp=0", pc_addrout); end
    n_chk++; if (pcp4 !== 32'h4) begin n_bad++; $display("FAIL ff_pcp4 got=%h exp=4", pcp4); end
    n_chk++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL ff_valid got=%b exp=1", id_valid); end
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL ff_req got=%b exp=1", imem_req); end
    n_chk++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL ff_addr got=%h exp=4", imem_addr); end
  endtask

  task automatic test_stall_skid();
    stall = 1'b1;
    cyc();
    imem_valid = 1'b1; imem_rdata = 32'h0020_8133;
    cyc();
    imem_valid = 1'b0;
    n_chk++; if (instrn !== 32'h0050_0093) begin n_bad++; $display("FAIL sk_hold_instr got=%h exp=00500093", instrn); end
    n_chk++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL sk_hold_valid got=%b exp=1", id_valid); end
    n_chk++; if (pc_addrout !== 32'h0) begin n_bad++; $display("FAIL sk_hold_pc got=%h exp=0", pc_addrout); end
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL sk_hold_req got=%b exp=0", imem_req); end
    cyc();
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL sk_hold2_req got=%b exp=0", imem_req); end
    n_chk++; if (instrn !== 32'h0050_0093) begin n_bad++; $display("FAIL sk_hold2_instr got=%h exp=00500093", instrn); end
    stall = 1'b0;
    cyc();
    n_chk++; if (instrn !== 32'h0020_8133) begin n_bad++; $display("FAIL sk_rel_instr got=%h exp=00208133", instrn); end
    n_chk++; if (pc_addrout !== 32'h4) begin n_bad++; $display("FAIL sk_rel_pc got=%h exp=4", pc_addrout); end
    n_chk++; if (pcp4 !== 32'h8) begin n_bad++; $display("FAIL sk_rel_pcp4 got=%h exp=8", pcp4); end
    n_chk++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL sk_rel_valid got=%b exp=1", id_valid); end
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL sk_rel_req got=%b exp=1", imem_req); end
    n_chk++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL sk_rel_addr got=%h exp=8", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    cyc();
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    n_chk++; if (instrn !== 32'h13) begin n_bad++; $display("FAIL rw_instr got=%h exp=00000013", instrn); end
    n_chk++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid got=%b exp=0", id_valid); end
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rw_req got=%b exp=0", imem_req); end
    n_chk++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL rw_addr got=%h exp=100", imem_addr); end
    cyc();
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rw_drop_req got=%b exp=0", imem_req); end
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_valid = 1'b0;
    n_chk++; if (instrn !== 32'h13) begin n_bad++; $display("FAIL rw_drop_instr got=%h exp=00000013", instrn); end
    n_chk++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rw_drop_valid got=%b exp=0", id_valid); end
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rw_next_req got=%b exp=1", imem_req); end
    n_chk++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL rw_next_addr got=%h exp=100", imem_addr); end
  endtask

  task automatic test_redirect_same();
    cyc();
    imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    imem_valid = 1'b0; redirect = 1'b0;
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rs_req got=%b exp=1", imem_req); end
    n_chk++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL rs_addr got=%h exp=200", imem_addr); end
    n_chk++; if (instrn !== 32'h13) begin n_bad++; $display("FAIL rs_instr got=%h exp=00000013", instrn); end
    n_chk++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rs_valid got=%b exp=0", id_valid); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL wr_drop_req got=%b exp=0", imem_req); end
    n_chk++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_drop_addr got=%h exp=fffffffc", imem_addr); end
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    imem_valid = 1'b0;
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL wr_req got=%b exp=1", imem_req); end
    cyc();
    imem_valid = 1'b1; imem_rdata = 32'h0010_0073;
    cyc();
    imem_valid = 1'b0;
    n_chk++; if (instrn !== 32'h0010_0073) begin n_bad++; $display("FAIL wr_instr got=%h exp=00100073", instrn); end
    n_chk++; if (pc_addrout !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wr_pc got=%h exp=fffffffc", pc_addrout); end
    n_chk++; if (pcp4 !== 32'h0) begin n_bad++; $display("FAIL wr_pcp4 got=%h exp=0", pcp4); end
    n_chk++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL wr_valid got=%b exp=1", id_valid); end
    n_chk++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wr_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_reset_in_hold();
    stall = 1'b1;
    cyc();
    imem_valid = 1'b1; imem_rdata = 32'hCAFE_BABE;
    cyc();
    imem_valid = 1'b0;
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rh_hold_req got=%b exp=0", imem_req); end
    rst = 1'b1;
    cyc();
    n_chk++; if (instrn !== 32'h13) begin n_bad++; $display("FAIL rh_instr got=%h exp=00000013", instrn); end
    n_chk++; if (pc_addrout !== 32'h0) begin n_bad++; $display("FAIL rh_pc got=%h exp=0", pc_addrout); end
    n_chk++; if (pcp4 !== 32'h4) begin n_bad++; $display("FAIL rh_pcp4 got=%h exp=4", pcp4); end
    n_chk++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rh_valid got=%b exp=0", id_valid); end
    n_chk++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rh_req got=%b exp=0", imem_req); end
    rst = 1'b0; stall = 1'b0;
    cyc();
    n_chk++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rh_req2 got=%b exp=1", imem_req); end
    n_chk++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rh_addr got=%h exp=0", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (instrn === 32'hCAFE_BABE) begin n_bad++; $display("FAIL rh_stale got=%h exp=!cafebabe", instrn); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_same();
    test_wrap();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
